btn_input_fifo: RTL and testbench
=================================

# btn_input_fifo

Buffers switch snapshots captured on debounced button edge pulses and presents them to the CPU-side MMIO read port as a first-word-fall-through queue. It sits directly downstream of the debounce/edge-detect stage: that stage produces a single-cycle `btn_edge` pulse, and this block latches `sw` on that pulse. The buffer lets several key-ins queue up while the CPU polls. An optional drop counter records pushes lost to overflow.

## Interface
- `DATA_W`, 16: width of the switch word and of each FIFO entry.
- `DEPTH`, 4: number of entries; must be a power of two, ≥ 2.
- `clk`  input  1: system clock; all state updates on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `btn_edge`  input  1: single-cycle pulse from the edge detector; this is the push request.
- `sw`  input  DATA_W: switch word, sampled in the cycle `btn_edge` is high.
- `rd_en`  input  1: pop request from the MMIO read logic.
- `rd_data`  output  DATA_W: head entry; reads 0 when the FIFO is empty.
- `valid`  output  1: FIFO not empty.
- `full`  output  1: count == DEPTH.
- `count`  output  $clog2(DEPTH)+1: number of stored entries.
- `ovf`  output  1: sticky overflow flag.
- `ovf_clr`  input  1: clears `ovf` (and the drop counter, when present).
- `drop_cnt`  output  8: exists only with `BTN_FIFO_DROP_CNT_EN`.

## Operation
- State: storage array, `wr_ptr` and `rd_ptr` (each $clog2(DEPTH) bits, wrapping modulo DEPTH), `count`, `ovf`.
- Push: `btn_edge` high and not full → `mem[wr_ptr] <= sw`, `wr_ptr+1`, `count+1`.
- Pop: `rd_en` high and `valid` → `rd_ptr+1`, `count-1`.
- Pop while empty: ignored; no pointer or count change.
- Push while full with no pop: the push is dropped, `ovf <= 1`, and stored data is unchanged.
- Push and pop in the same cycle while full: both take effect; the pop frees the slot; `count` stays at DEPTH; no overflow.
- Push and pop in the same cycle while empty: only the push takes effect (no FWFT bypass); `count` becomes 1.
- Push and pop in the same cycle otherwise: both take effect; `count` is unchanged.
- `ovf_clr` high in the same cycle as an overflowing push: the set wins; `ovf` stays 1.
- Pointer wrap: after DEPTH pushes, `wr_ptr` returns to 0; `full` and empty are derived from `count`, never from pointer equality.

## Timing
- Reset, in the cycle `rst` is high: `wr_ptr`, `rd_ptr`, `count`, `ovf` and `drop_cnt` go to 0, so `valid`=0, `full`=0 and `rd_data`=0. The storage array is not reset.
- `rst` overrides every simultaneous push, pop or clear.
- Push-to-visible latency is 1 cycle: `valid` and `rd_data` reflect the new entry in the cycle after `btn_edge`.
- `rd_data` is combinational from `mem[rd_ptr]`, masked to 0 when `count`==0.
- After a pop on edge N, the next head appears on `rd_data` in cycle N+1.
- `full`, `valid` and `count` are registered-state-derived; they have no combinational path from the inputs.

## Configuration
- `BTN_FIFO_DROP_CNT_EN` defined:
  - Adds the 8-bit `drop_cnt` port.
  - The counter increments on every dropped push and saturates at 255.
  - It is cleared by `rst` or `ovf_clr`; a drop in the same cycle as `ovf_clr` leaves it at 1.
- `BTN_FIFO_DROP_CNT_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package holds:
  - default `DATA_W` and `DEPTH`;
  - the derived pointer width `PTR_W = $clog2(DEPTH)` and count width `PTR_W+1`;
  - the MMIO offsets where the CPU reads `rd_data`, `{ovf, full, valid}` and triggers `rd_en`.
- One natural sub-module: `btn_fifo_mem`, a DEPTH×DATA_W register array with a synchronous write port and an asynchronous read port. Pointers, count and flags stay in the top.

## Test plan
- Reset, then idle: `valid`=0, `full`=0, `count`=0, `rd_data`=0, `ovf`=0.
- Push `sw`=0x1234, 0xABCD, then pop twice: `rd_data` shows 0x1234 one cycle after the first push and 0xABCD after the first pop; `valid`=0 after the second pop.
- Push 5 words 0x0001–0x0005 with DEPTH=4: `full`=1 after 4 pushes, `ovf`=1 and `drop_cnt`=1 after the 5th, and pops return 0x0001–0x0004.
- With the FIFO full, push 0x00FF and pop in the same cycle: `count` stays 4, `ovf` stays 0, and 0x00FF is the last of the 4 entries popped.
- Pop on empty, then `ovf_clr` during an overflowing push: the pop changes nothing; `ovf` stays 1.
- Push and pop 12 times to wrap the pointers 3 times: data order is preserved; assert `rst` mid-sequence → all flags 0 on the next cycle.

Source files
------------

// File: rtl/btn_input_fifo_pkg.sv
// Shared defaults, derived widths and CPU-visible MMIO offsets for the button input FIFO.
package btn_input_fifo_pkg;

   localparam int unsigned BTN_DATA_W = 16;
   localparam int unsigned BTN_DEPTH  = 4;
   localparam int unsigned BTN_PTR_W  = $clog2(BTN_DEPTH);
   localparam int unsigned BTN_CNT_W  = BTN_PTR_W + 1;

   // Byte offsets decoded by the MMIO read logic; STATUS reads {ovf, full, valid}.
   typedef enum logic [3:0] {
      MMIO_RD_DATA = 4'h0,
      MMIO_STATUS  = 4'h4,
      MMIO_POP     = 4'h8
   } btn_mmio_off_e;

   function automatic logic [2:0] btn_status_word(input logic ovf, input logic full,
                                                  input logic valid);
      return {ovf, full, valid};
   endfunction

endpackage

// File: rtl/btn_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read. Not reset.
module btn_fifo_mem
   import btn_input_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = BTN_DATA_W,
   parameter int unsigned DEPTH  = BTN_DEPTH,
   parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [PTR_W-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [PTR_W-1:0]  raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/btn_input_fifo.sv
// FWFT queue of switch snapshots captured on debounced button edges.
// Define BTN_FIFO_DROP_CNT_EN to add the saturating 8-bit drop_cnt output.
module btn_input_fifo
   import btn_input_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = BTN_DATA_W,
   parameter int unsigned DEPTH  = BTN_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     btn_edge,
   input  logic [DATA_W-1:0]        sw,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     valid,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf,
   input  logic                     ovf_clr
`ifdef BTN_FIFO_DROP_CNT_EN
  ,output logic [7:0]               drop_cnt
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              push_ok, pop_ok, drop;
   logic              empty;
   logic [DATA_W-1:0] head;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));
   assign valid = ~empty;
   assign count = count_q;
   assign ovf   = ovf_q;

   // A pop frees the slot a simultaneous push lands in, so full + pop still accepts the push.
   always_comb begin
      pop_ok  = rd_en & ~empty;
      push_ok = btn_edge & (~full | pop_ok);
      drop    = btn_edge & full & ~pop_ok;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      if (drop) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

`ifdef BTN_FIFO_DROP_CNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (ovf_clr) begin
         drop_cnt_d = drop ? 8'd1 : 8'd0;
      end else if (drop && drop_cnt_q != 8'hFF) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`endif

   btn_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (push_ok),
      .waddr_i (wr_ptr_q),
      .wdata_i (sw),
      .raddr_i (rd_ptr_q),
      .rdata_o (head)
   );

   assign rd_data = empty ? '0 : head;

endmodule

// File: tb/tb_btn_input_fifo.sv
// Scoreboard bench for btn_input_fifo (DEPTH=4, DATA_W=16); drop_cnt checks follow BTN_FIFO_DROP_CNT_EN.
module tb_btn_input_fifo;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn_edge = 1'b0;
   logic [15:0] sw = '0;
   logic        rd_en = 1'b0;
   logic        ovf_clr = 1'b0;
   logic [15:0] rd_data;
   logic        valid;
   logic        full;
   logic [2:0]  count;
   logic        ovf;
`ifdef BTN_FIFO_DROP_CNT_EN
   logic [7:0]  drop_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;
   logic [15:0] exp_q[$];

   btn_input_fifo #(
      .DATA_W (16),
      .DEPTH  (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_edge (btn_edge),
      .sw       (sw),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .valid    (valid),
      .full     (full),
      .count    (count),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr)
`ifdef BTN_FIFO_DROP_CNT_EN
     ,.drop_cnt (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Monitor: every accepted pop must present the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && rd_en && valid) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL pop_data: got %h, required no entry (scoreboard empty)", rd_data);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (rd_data !== e) begin
               n_errors++;
               $display("FAIL pop_data: got %h, required %h", rd_data, e);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // One clock of stimulus; acc says whether the bench expects the push to be stored.
   task automatic step(input logic be, input logic [15:0] s, input logic re,
                       input logic clr, input logic acc);
      btn_edge = be;
      sw       = s;
      rd_en    = re;
      ovf_clr  = clr;
      if (be && acc) exp_q.push_back(s);
      @(posedge clk);
      #1;
      btn_edge = 1'b0;
      rd_en    = 1'b0;
      ovf_clr  = 1'b0;
      sw       = '0;
   endtask

   task automatic push(input logic [15:0] s, input logic acc);
      step(1'b1, s, 1'b0, 1'b0, acc);
   endtask

   task automatic pop();
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   initial begin
      // Reset, then idle
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      settle();
      chk("rst_valid", valid, 0);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_ovf", ovf, 0);

      // Two pushes, two pops
      push(16'h1234, 1'b1);
      settle();
      chk("p1_valid", valid, 1);
      chk("p1_head", rd_data, 16'h1234);
      push(16'hABCD, 1'b1);
      pop();
      settle();
      chk("p2_head", rd_data, 16'hABCD);
      pop();
      settle();
      chk("p2_empty", valid, 0);

      // Overflow with five pushes
      for (int i = 1; i <= 4; i++) push(16'(i), 1'b1);
      settle();
      chk("of_full", full, 1);
      chk("of_count4", count, 4);
      chk("of_ovf_pre", ovf, 0);
      push(16'h0005, 1'b0);
      settle();
      chk("of_ovf", ovf, 1);
      chk("of_count_hold", count, 4);
`ifdef BTN_FIFO_DROP_CNT_EN
      chk("of_drop_cnt", drop_cnt, 1);
`endif
      for (int i = 0; i < 4; i++) pop();
      settle();
      chk("of_drained", valid, 0);
      chk("of_ovf_sticky", ovf, 1);
      step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      settle();
      chk("of_ovf_clr", ovf, 0);
`ifdef BTN_FIFO_DROP_CNT_EN
      chk("of_drop_clr", drop_cnt, 0);
`endif

      // Push + pop while full
      for (int i = 0; i < 4; i++) push(16'h0010 + 16'(i), 1'b1);
      step(1'b1, 16'h00FF, 1'b1, 1'b0, 1'b1);
      settle();
      chk("fpp_count", count, 4);
      chk("fpp_full", full, 1);
      chk("fpp_ovf", ovf, 0);
      chk("fpp_head", rd_data, 16'h0011);
      for (int i = 0; i < 4; i++) pop();
      settle();
      chk("fpp_drained", count, 0);

      // Pop on empty, push + pop on empty
      pop();
      settle();
      chk("pe_count", count, 0);
      chk("pe_rd_data", rd_data, 0);
      step(1'b1, 16'h0030, 1'b1, 1'b0, 1'b1);
      settle();
      chk("epp_count", count, 1);
      chk("epp_head", rd_data, 16'h0030);
      pop();

      // Clear during an overflowing push: set wins
      for (int i = 0; i < 4; i++) push(16'h0021 + 16'(i), 1'b1);
      step(1'b1, 16'h0025, 1'b0, 1'b1, 1'b0);
      settle();
      chk("clr_ovf_set_wins", ovf, 1);
      chk("clr_count", count, 4);
`ifdef BTN_FIFO_DROP_CNT_EN
      chk("clr_drop_cnt", drop_cnt, 1);
`endif
      for (int i = 0; i < 4; i++) pop();

      // Wrap pointers; reset mid-sequence while ovf is still set
      for (int i = 0; i < 12; i++) begin
         push(16'h0100 + 16'(i), 1'b1);
         if (i == 6) begin
            settle();
            chk("wrap_pre_rst_valid", valid, 1);
            exp_q.delete();
            rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            settle();
            chk("wrap_rst_valid", valid, 0);
            chk("wrap_rst_full", full, 0);
            chk("wrap_rst_count", count, 0);
            chk("wrap_rst_ovf", ovf, 0);
            chk("wrap_rst_rd_data", rd_data, 0);
         end else begin
            pop();
         end
      end
      settle();
      chk("wrap_end_count", count, 0);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish, required finish before 20000");
      $fatal(1);
   end

endmodule
